// File: rtl/interval_timer_ctrl_if.sv
// rtl/interval_timer_ctrl_if.sv - request/status bundle for the interval timer controller
interface interval_timer_ctrl_if #(
  parameter int WIDTH   = 4,
  parameter int PRESC_W = 4
);
  logic               start;
  logic               stop;
  logic               mode;
  logic [WIDTH-1:0]   limit;
  logic [PRESC_W-1:0] prescale;
  logic [WIDTH-1:0]   count;
  logic               busy;
  logic               tick;
  logic               done;

  // Requester side: issues start/stop and configuration, observes status
  modport master (
    output start, stop, mode, limit, prescale,
    input  count, busy, tick, done
  );

  // Timer side
  modport slave (
    input  start, stop, mode, limit, prescale,
    output count, busy, tick, done
  );
endinterface

// File: rtl/interval_timer_ctrl.sv
// rtl/interval_timer_ctrl.sv - start/stop interval timer FSM; optional prescaler under INTERVAL_TIMER_PRESCALE_EN
module interval_timer_ctrl #(
  parameter int WIDTH   = 4,
  parameter int PRESC_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  interval_timer_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ONE = 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             advance;
  logic             start_accept;

  // A start is honoured from IDLE and DONE; RUN never restarts.
  assign start_accept = bus.start && (state_q != S_RUN);

`ifdef INTERVAL_TIMER_PRESCALE_EN
  localparam logic [PRESC_W-1:0] PRESC_ONE = 1;

  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [PRESC_W-1:0] prescale_q, prescale_d;

  // Prescaler: counts up to the latched compare, one advance per wrap; cleared on start and on any exit from RUN
  always_comb begin
    advance     = 1'b0;
    presc_cnt_d = presc_cnt_q;
    prescale_d  = prescale_q;
    if (start_accept) begin
      prescale_d  = bus.prescale;
      presc_cnt_d = '0;
    end else if (state_q == S_RUN) begin
      if (bus.stop) begin
        presc_cnt_d = '0;
      end else if (presc_cnt_q == prescale_q) begin
        advance     = 1'b1;
        presc_cnt_d = '0;
      end else begin
        presc_cnt_d = presc_cnt_q + PRESC_ONE;
      end
    end
  end

  // Prescaler registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt_q <= '0;
      prescale_q  <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      prescale_q  <= prescale_d;
    end
  end
`else
  // Without the prescaler every RUN cycle advances; the compare input is sunk.
  logic [PRESC_W-1:0] unused_prescale;
  assign unused_prescale = bus.prescale;
  assign advance         = (state_q == S_RUN);
`endif

  // Next-state and datapath: stop beats terminal in RUN, start beats stop in IDLE/DONE
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    mode_d  = mode_q;
    tick_d  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          limit_d = bus.limit;
          mode_d  = bus.mode;
          count_d = '0;
          state_d = S_RUN;
        end else if (bus.stop && (state_q == S_DONE)) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (advance) begin
          if (count_q == limit_q) begin
            tick_d = 1'b1;
            if (mode_q) begin
              count_d = '0;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      limit_q <= '0;
      mode_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tick  = tick_q;
  assign bus.busy  = (state_q == S_RUN);
  assign bus.done  = (state_q == S_DONE);

endmodule
